// File: rtl/sha_kw_sequencer.sv
// rtl/sha_kw_sequencer.sv - SHA-256 K+W round sequencer: loads a 16-word block, expands W, drives the K ROM.
module sha_kw_sequencer #(
    parameter int ADDR_WTH = 6,
    parameter int WRD_SIZE = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [WRD_SIZE-1:0] i_word,
    input  logic                i_word_valid,
    output logic                o_word_ready,
    output logic [ADDR_WTH-1:0] o_rc_add,
    output logic                o_rc_enable,
    input  logic [WRD_SIZE-1:0] i_rc_data,
    output logic [WRD_SIZE-1:0] o_kw,
    output logic                o_kw_valid,
    output logic [ADDR_WTH-1:0] o_round,
    output logic                o_last,
    input  logic                i_hold,
    output logic                o_done
);
    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_DONE} state_t;

    localparam logic [ADDR_WTH-1:0] LAST_IDX = '1;
    localparam logic [ADDR_WTH-1:0] IDX_ONE  = {{(ADDR_WTH-1){1'b0}}, 1'b1};

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic [ADDR_WTH-1:0] r_idx;
    logic [WRD_SIZE-1:0] r_win [16];
    logic [WRD_SIZE-1:0] w_new;
    logic                w_take;

    function automatic logic [31:0] small_s0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_s1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // r_win[0] is always W[idx]; the sliding window yields W[idx+16] from the standard taps.
    assign w_new  = small_s1(r_win[14]) + r_win[9] + small_s0(r_win[1]) + r_win[0];
    assign w_take = (r_state == S_RUN) && !i_hold;

    assign o_word_ready = (r_state == S_IDLE);
    assign o_rc_enable  = (r_state == S_PRIME) || (r_state == S_RUN);
    assign o_kw_valid   = (r_state == S_RUN);
    assign o_done       = (r_state == S_DONE);
    assign o_round      = r_idx;
    assign o_last       = (r_state == S_RUN) && (r_idx == LAST_IDX);
    assign o_kw         = i_rc_data + r_win[0];

    // The ROM is one cycle behind, so the address leads by one round unless the round is held.
    always_comb begin
        o_rc_add = '0;
        if (r_state == S_RUN) begin
            if (i_hold || (r_idx == LAST_IDX)) begin
                o_rc_add = r_idx;
            end else begin
                o_rc_add = r_idx + IDX_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            for (int i = 0; i < 16; i++) begin
                r_win[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_word_valid) begin
                        r_win[r_cnt] <= i_word;
                        r_cnt        <= r_cnt + 4'd1;
                        if (r_cnt == 4'd15) begin
                            r_state <= S_PRIME;
                        end
                    end
                end
                S_PRIME: begin
                    r_idx   <= '0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_take) begin
                        for (int i = 0; i < 15; i++) begin
                            r_win[i] <= r_win[i+1];
                        end
                        r_win[15] <= w_new;
                        r_idx     <= r_idx + IDX_ONE;
                        if (r_idx == LAST_IDX) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sha_kw_sequencer.sv
// tb/tb_sha_kw_sequencer.sv - directed, table-driven bench for sha_kw_sequencer with a K ROM model.
module tb_sha_kw_sequencer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] i_word = '0;
    logic        i_word_valid = 1'b0;
    logic        o_word_ready;
    logic [5:0]  o_rc_add;
    logic        o_rc_enable;
    logic [31:0] rom_q = '0;
    logic [31:0] o_kw;
    logic        o_kw_valid;
    logic [5:0]  o_round;
    logic        o_last;
    logic        i_hold = 1'b0;
    logic        o_done;

    int checks = 0;
    int fails  = 0;

    logic [31:0] k_tab [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic [31:0] msg    [16];
    logic [31:0] ref_kw [64];
    logic [31:0] kw_got [64];

    typedef struct {
        int          rnd;
        logic [31:0] kw;
    } vec_t;

    vec_t vecs [7];

    sha_kw_sequencer #(.ADDR_WTH(6), .WRD_SIZE(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_word       (i_word),
        .i_word_valid (i_word_valid),
        .o_word_ready (o_word_ready),
        .o_rc_add     (o_rc_add),
        .o_rc_enable  (o_rc_enable),
        .i_rc_data    (rom_q),
        .o_kw         (o_kw),
        .o_kw_valid   (o_kw_valid),
        .o_round      (o_round),
        .o_last       (o_last),
        .i_hold       (i_hold),
        .o_done       (o_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_q <= o_rc_enable ? k_tab[o_rc_add] : 32'h0;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic build_ref();
        logic [31:0] w [64];
        for (int t = 0; t < 16; t++) w[t] = msg[t];
        for (int t = 16; t < 64; t++) begin
            w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        end
        for (int t = 0; t < 64; t++) ref_kw[t] = k_tab[t] + w[t];
    endtask

    // Called at posedge+1 while the DUT is in IDLE; leaves it in PRIME.
    task automatic load_block(input bit gaps);
        int acc = 0;
        int guard = 0;
        bit v;
        bit rdy;
        while (acc < 16 && guard < 200) begin
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            i_word_valid = v;
            i_word = msg[acc];
            #1;
            rdy = o_word_ready;
            @(posedge clk);
            #1;
            if (v && rdy) acc++;
            guard++;
        end
        chk("load_word_count", 32'(acc), 32'd16);
        i_word_valid = 1'b1;
        i_word = 32'hDEADBEEF;
        chk("prime_ready", {31'b0, o_word_ready}, 32'd0);
        chk("prime_rc_en", {31'b0, o_rc_enable}, 32'd1);
        chk("prime_rc_add", {26'b0, o_rc_add}, 32'd0);
        chk("prime_kw_valid", {31'b0, o_kw_valid}, 32'd0);
    endtask

    task automatic run_block(input int hold_round, input int hold_len, output int valid_cycles);
        int expect_r = 0;
        int held = 0;
        int guard = 0;
        bit done_seen = 0;
        valid_cycles = 0;
        for (int t = 0; t < 64; t++) kw_got[t] = '0;
        while (!done_seen && guard < 300) begin
            @(posedge clk);
            #1;
            guard++;
            if (o_done) begin
                done_seen = 1;
                i_word_valid = 1'b0;
                chk("done_after_round63", 32'(expect_r), 32'd64);
                chk("done_kw_valid", {31'b0, o_kw_valid}, 32'd0);
                chk("done_rc_en", {31'b0, o_rc_enable}, 32'd0);
                chk("done_ready", {31'b0, o_word_ready}, 32'd0);
            end else begin
                chk("run_kw_valid", {31'b0, o_kw_valid}, 32'd1);
                valid_cycles++;
                chk("run_ready", {31'b0, o_word_ready}, 32'd0);
                chk("run_rc_en", {31'b0, o_rc_enable}, 32'd1);
                chk("run_round", {26'b0, o_round}, 32'(expect_r));
                chk("run_last", {31'b0, o_last}, {31'b0, expect_r == 63});
                if (expect_r == hold_round && held < hold_len) begin
                    i_hold = 1'b1;
                    held++;
                    #1;
                    chk("hold_rc_add", {26'b0, o_rc_add}, 32'(hold_round));
                    chk("hold_kw", o_kw, ref_kw[hold_round]);
                end else begin
                    i_hold = 1'b0;
                    #1;
                    chk("take_rc_add", {26'b0, o_rc_add}, 32'(expect_r == 63 ? 63 : expect_r + 1));
                    if (expect_r < 64) kw_got[expect_r] = o_kw;
                    expect_r++;
                end
            end
        end
        i_hold = 1'b0;
        if (!done_seen) chk("run_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        chk("post_done_ready", {31'b0, o_word_ready}, 32'd1);
    endtask

    task automatic check_table(input string tag);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("%s_round%0d", tag, vecs[i].rnd), kw_got[vecs[i].rnd], vecs[i].kw);
        end
    endtask

    initial begin
        int vc;
        int guard;
        logic [31:0] first_r0;

        vecs = '{'{0, 32'hA3EC9318}, '{1, 32'h71374491}, '{5, 32'h59F111F1}, '{6, 32'h923F82A4},
                 '{15, 32'hC19BF18C}, '{16, 32'h45FDCD41}, '{17, 32'hEFCD4786}};
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        msg[0]  = 32'h61626380;
        msg[15] = 32'h00000018;
        build_ref();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_kw_valid", {31'b0, o_kw_valid}, 32'd0);
        chk("rst_done", {31'b0, o_done}, 32'd0);
        chk("rst_rc_en", {31'b0, o_rc_enable}, 32'd0);
        chk("rst_rc_add", {26'b0, o_rc_add}, 32'd0);
        chk("rst_round", {26'b0, o_round}, 32'd0);
        chk("rst_ready", {31'b0, o_word_ready}, 32'd1);
        reset_n = 1'b1;

        // "abc" block, no holds, full reference comparison
        load_block(1'b0);
        run_block(-1, 0, vc);
        chk("nohold_valid_cycles", 32'(vc), 32'd64);
        check_table("nohold");
        for (int t = 0; t < 64; t++) chk($sformatf("full_kw%0d", t), kw_got[t], ref_kw[t]);

        // Hold at round 5 for three cycles
        load_block(1'b0);
        run_block(5, 3, vc);
        chk("hold5_valid_cycles", 32'(vc), 32'd67);
        check_table("hold5");

        // Gapped load, then back-to-back second block
        load_block(1'b1);
        run_block(-1, 0, vc);
        first_r0 = kw_got[0];
        chk("gap1_round0", first_r0, 32'hA3EC9318);
        load_block(1'b1);
        run_block(-1, 0, vc);
        chk("gap2_round0", kw_got[0], first_r0);
        chk("gap2_valid_cycles", 32'(vc), 32'd64);

        // Hold at round 63 for two cycles
        load_block(1'b0);
        run_block(63, 2, vc);
        chk("hold63_valid_cycles", 32'(vc), 32'd66);
        chk("hold63_round63", kw_got[63], ref_kw[63]);

        // Reset mid-run at round 30
        load_block(1'b0);
        i_word_valid = 1'b0;
        guard = 0;
        while (!(o_kw_valid && o_round == 6'd30) && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("midrun_reached_30", {26'b0, o_round}, 32'd30);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_kw_valid", {31'b0, o_kw_valid}, 32'd0);
        chk("midrst_rc_en", {31'b0, o_rc_enable}, 32'd0);
        chk("midrst_ready", {31'b0, o_word_ready}, 32'd1);
        reset_n = 1'b1;
        load_block(1'b0);
        run_block(-1, 0, vc);
        chk("after_rst_round0", kw_got[0], 32'hA3EC9318);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
